// File: rtl/pll_lock_ctrl.sv
// ============================================================================
//  Module   : pll_lock_ctrl
//  Purpose  : PLL reset/lock sequencer; holds downstream logic in reset until
//             lock is qualified. Optional IRQ: PLL_LOCK_CTRL_IRQ_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pll_lock_ctrl #(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 5000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       locked_stable,
    output logic       timeout_err,
    output logic [7:0] relock_count,
    output logic [2:0] ctrl_state
`ifdef PLL_LOCK_CTRL_IRQ_EN
    ,
    output logic       irq,
    input  logic       irq_clr
`endif
);

    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] C_MAX_RETRIES = RET_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [RET_W-1:0] r_retries;
    logic [RET_W-1:0] w_retries_nxt;
    logic [RET_W-1:0] w_retries_inc;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             w_restart;
    logic             w_loss;
    logic             w_entry;

    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_locked_stable;
    logic             r_timeout_err;
    logic [7:0]       r_relock_count;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_retries_inc = r_retries + RET_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_retries_nxt = r_retries;
        w_restart     = 1'b0;
        w_loss        = 1'b0;
        if (sw_relock) begin
            w_state_nxt   = S_RESET_PLL;
            w_retries_nxt = '0;
            w_restart     = 1'b1;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == C_RST_LAST) w_state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock
                    if (r_lock_s) begin
                        w_state_nxt = S_STABILIZE;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        w_retries_nxt = w_retries_inc;
                        w_state_nxt   = (w_retries_inc == C_MAX_RETRIES) ? S_FAULT : S_RESET_PLL;
                    end
                end
                S_STABILIZE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else if (r_cnt == C_STABLE_LAST) begin
                        w_state_nxt   = S_RUN;
                        w_retries_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_RESET_PLL;
                        w_loss      = 1'b1;
                    end
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                end
            endcase
        end
        // A software restart re-enters RESET_PLL even when already there
        w_entry   = w_restart || (w_state_nxt != r_state);
        w_cnt_nxt = w_entry ? '0 : r_cnt + CNT_W'(1);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state         <= S_RESET_PLL;
            r_cnt           <= '0;
            r_retries       <= '0;
            r_pll_rst       <= 1'b1;
            r_sys_rst       <= 1'b1;
            r_locked_stable <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_relock_count  <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_retries       <= w_retries_nxt;
            r_pll_rst       <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
            r_sys_rst       <= (w_state_nxt != S_RUN);
            r_locked_stable <= (w_state_nxt == S_RUN);
            r_timeout_err   <= (w_state_nxt == S_FAULT);
            if (w_loss && (r_relock_count != 8'hFF)) begin
                r_relock_count <= r_relock_count + 8'd1;
            end
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign locked_stable = r_locked_stable;
    assign timeout_err   = r_timeout_err;
    assign relock_count  = r_relock_count;
    assign ctrl_state    = r_state;

`ifdef PLL_LOCK_CTRL_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    assign w_irq_set = w_loss || ((w_state_nxt == S_FAULT) && (r_state != S_FAULT));

    // Set has priority over a coincident clear
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
// ============================================================================
//  Module   : tb_pll_lock_ctrl
//  Purpose  : Directed self-checking bench for pll_lock_ctrl (small parameters).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_ctrl;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       sw_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       locked_stable;
    logic       timeout_err;
    logic [7:0] relock_count;
    logic [2:0] ctrl_state;
`ifdef PLL_LOCK_CTRL_IRQ_EN
    logic       irq;
    logic       irq_clr;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int n;

    pll_lock_ctrl #(
        .RST_HOLD_CYCLES   (4),
        .LOCK_TIMEOUT      (20),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (2),
        .CNT_W             (16)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sw_relock    (sw_relock),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .locked_stable(locked_stable),
        .timeout_err  (timeout_err),
        .relock_count (relock_count),
        .ctrl_state   (ctrl_state)
`ifdef PLL_LOCK_CTRL_IRQ_EN
        ,
        .irq          (irq),
        .irq_clr      (irq_clr)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge refclk);
        #1;
    endtask

    task automatic count_pll_rst(output int c);
        c = 0;
        do begin
            step(1);
            c++;
        end while (pll_rst === 1'b1 && c < 100);
    endtask

    task automatic count_sys_rst(output int c);
        c = 0;
        do begin
            step(1);
            c++;
        end while (sys_rst === 1'b1 && c < 100);
    endtask

    task automatic count_state(input logic [2:0] s, output int c);
        c = 0;
        do begin
            step(1);
            c++;
        end while (ctrl_state === s && c < 200);
    endtask

    task automatic wait_run(input string tag);
        int c;
        c = 0;
        while (ctrl_state !== 3'd3 && c < 100) begin
            step(1);
            c++;
        end
        check(tag, 32'(ctrl_state), 32'd3);
    endtask

    task automatic loss_cycle();
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        wait_run("sat_rerun");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        sw_relock  = 1'b0;
`ifdef PLL_LOCK_CTRL_IRQ_EN
        irq_clr    = 1'b0;
`endif
        step(3);
        check("rst_state", 32'(ctrl_state), 32'd0);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_sys_rst", 32'(sys_rst), 32'd1);
        check("rst_locked_stable", 32'(locked_stable), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_relock_count", 32'(relock_count), 32'd0);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif

        // Normal lock
        rst = 1'b0;
        count_pll_rst(n);
        check("norm_pll_rst_len", 32'(n), 32'd4);
        check("norm_enter_wait", 32'(ctrl_state), 32'd1);
        step(2);
        pll_locked = 1'b1;
        check("norm_still_wait", 32'(ctrl_state), 32'd1);
        step(3);
        check("norm_enter_stab", 32'(ctrl_state), 32'd2);
        check("norm_stab_sys_rst", 32'(sys_rst), 32'd1);
        count_sys_rst(n);
        check("norm_stab_len", 32'(n), 32'd8);
        check("norm_run_state", 32'(ctrl_state), 32'd3);
        check("norm_locked_stable", 32'(locked_stable), 32'd1);
        check("norm_run_pll_rst", 32'(pll_rst), 32'd0);

        // Single lock loss in RUN
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        check("loss_sync_latency", 32'(ctrl_state), 32'd3);
        step(1);
        check("loss_state", 32'(ctrl_state), 32'd0);
        check("loss_count", 32'(relock_count), 32'd1);
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_locked_stable", 32'(locked_stable), 32'd0);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        check("loss_irq_set", 32'(irq), 32'd1);
`endif
        step(3);
        check("loss_pll_rst_hold", 32'(pll_rst), 32'd1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        check("loss_irq_sticky", 32'(irq), 32'd1);
        irq_clr = 1'b1;
`endif
        step(1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        irq_clr = 1'b0;
        check("loss_irq_cleared", 32'(irq), 32'd0);
`endif
        check("loss_pll_rst_fall", 32'(pll_rst), 32'd0);
        check("loss_wait", 32'(ctrl_state), 32'd1);
        step(1);
        check("loss_stab", 32'(ctrl_state), 32'd2);
        count_state(3'd2, n);
        check("loss_stab_len", 32'(n), 32'd8);
        check("loss_rerun", 32'(ctrl_state), 32'd3);

        // sw_relock coincident with lock loss in RUN
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        sw_relock = 1'b1;
        step(1);
        sw_relock = 1'b0;
        check("swloss_state", 32'(ctrl_state), 32'd0);
        check("swloss_count", 32'(relock_count), 32'd1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        check("swloss_irq", 32'(irq), 32'd0);
`endif
        wait_run("swloss_rerun");

        // Glitch in STABILIZE coinciding with its final count
        sw_relock = 1'b1;
        step(1);
        sw_relock = 1'b0;
        check("glitch_restart", 32'(ctrl_state), 32'd0);
        step(4);
        check("glitch_wait", 32'(ctrl_state), 32'd1);
        step(1);
        check("glitch_stab", 32'(ctrl_state), 32'd2);
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        check("glitch_hold", 32'(ctrl_state), 32'd2);
        step(1);
        check("glitch_back_wait", 32'(ctrl_state), 32'd1);
        check("glitch_sys_rst", 32'(sys_rst), 32'd1);
        step(1);
        check("glitch_restab", 32'(ctrl_state), 32'd2);
        count_state(3'd2, n);
        check("glitch_requal_len", 32'(n), 32'd8);
        check("glitch_run", 32'(ctrl_state), 32'd3);

        // Repeated losses: counter saturates at 255
        for (int i = 0; i < 253; i++) loss_cycle();
        check("sat_254", 32'(relock_count), 32'd254);
        for (int i = 0; i < 47; i++) loss_cycle();
        check("sat_255", 32'(relock_count), 32'd255);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
        check("sat_irq_clr", 32'(irq), 32'd0);
`endif

        // No lock: two timed-out attempts then FAULT
        pll_locked = 1'b0;
        sw_relock  = 1'b1;
        step(1);
        sw_relock  = 1'b0;
        check("nolock_restart", 32'(ctrl_state), 32'd0);
        count_pll_rst(n);
        check("nolock_rst1_len", 32'(n), 32'd4);
        count_state(3'd1, n);
        check("nolock_win1_len", 32'(n), 32'd20);
        check("nolock_retry", 32'(ctrl_state), 32'd0);
        count_pll_rst(n);
        check("nolock_rst2_len", 32'(n), 32'd4);
        step(19);
        check("nolock_win2_open", 32'(ctrl_state), 32'd1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        irq_clr = 1'b1;
`endif
        step(1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        irq_clr = 1'b0;
        check("fault_irq_set_wins", 32'(irq), 32'd1);
`endif
        check("fault_state", 32'(ctrl_state), 32'd4);
        check("fault_timeout_err", 32'(timeout_err), 32'd1);
        check("fault_pll_rst", 32'(pll_rst), 32'd1);
        check("fault_sys_rst", 32'(sys_rst), 32'd1);
        step(30);
        check("fault_hold_state", 32'(ctrl_state), 32'd4);
        check("fault_hold_pll_rst", 32'(pll_rst), 32'd1);
        check("fault_hold_err", 32'(timeout_err), 32'd1);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        check("fault_hold_irq", 32'(irq), 32'd1);
`endif

        // sw_relock leaves FAULT
        sw_relock = 1'b1;
        step(1);
        sw_relock = 1'b0;
        check("swfault_state", 32'(ctrl_state), 32'd0);
        check("swfault_err", 32'(timeout_err), 32'd0);
        check("swfault_pll_rst", 32'(pll_rst), 32'd1);
        check("swfault_count", 32'(relock_count), 32'd255);

        // rst in the middle of WAIT_LOCK
        step(4);
        check("midrst_wait", 32'(ctrl_state), 32'd1);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_state", 32'(ctrl_state), 32'd0);
        check("midrst_pll_rst", 32'(pll_rst), 32'd1);
        check("midrst_sys_rst", 32'(sys_rst), 32'd1);
        check("midrst_locked_stable", 32'(locked_stable), 32'd0);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        check("midrst_count", 32'(relock_count), 32'd0);
`ifdef PLL_LOCK_CTRL_IRQ_EN
        check("midrst_irq", 32'(irq), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
